ps2_scancode_decoder: RTL and testbench
=======================================

Name: ps2_scancode_decoder

Overview:
- Downstream stage of the PS/2 keyboard receiver. Consumes raw Set-2 scan-code bytes and folds the E0 (extended) and F0 (break) prefixes into single key events.
- Tracks the shift/ctrl/alt modifier state and presents events on a valid/ready interface to the application logic (LED/7-seg display, ASCII mapper).
- Bytes flagged with a parity error are discarded, and any partial prefix sequence is abandoned.

Parameters:
- TIMEOUT_CYC, 100000, dspclk cycles allowed between bytes of one prefixed sequence before it is abandoned (1 ms at 100 MHz).
- TO_W, 17, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYC.

Ports:
- dspclk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  received scan-code byte.
- rx_valid  in  1  one-cycle strobe; rx_data and rx_err are valid in this cycle.
- rx_err  in  1  parity/framing error for the byte; qualified by rx_valid.
- evt_valid  out  1  key event available.
- evt_ready  in  1  consumer accepts the event; transfer occurs when evt_valid && evt_ready.
- evt_code  out  8  base scan code, prefixes stripped.
- evt_ext  out  1  event carried the E0 prefix.
- evt_break  out  1  1 = key release, 0 = key press.
- mod_shift  out  1  left or right shift currently held.
- mod_ctrl  out  1  left or right ctrl currently held.
- mod_alt  out  1  left or right alt currently held.
- overflow  out  1  sticky: an event was dropped because the output was full.
- ovf_clr  in  1  clears overflow.
- led  out  8  base code of the last press event accepted into the output register.

Behaviour:
- Reset (synchronous, active-high) clears all of the following:
  - outputs: evt_valid, evt_code, evt_ext, evt_break, all mod_*, overflow, led;
  - FSM state returns to S_IDLE;
  - the timeout counter and the four internal modifier flags (lshift, rshift, ctrl, alt).
- Reset asserted mid-sequence discards the partial sequence; no event is produced.
- FSM states: S_IDLE, S_E0, S_F0, S_E0F0. A transition happens only on cycles with rx_valid=1.
  - rx_valid && rx_err, in any state: byte dropped, state -> S_IDLE, no event.
  - S_IDLE:
    - E0 -> S_E0.
    - F0 -> S_F0.
    - AA, FA, FE, EE, 00, FF: dropped, stay in S_IDLE.
    - any other byte: emit press event, ext=0.
  - S_E0:
    - F0 -> S_E0F0.
    - E0 -> stay.
    - 00 or FF -> S_IDLE with no event.
    - other: emit press, ext=1, -> S_IDLE.
  - S_F0:
    - 00 or FF -> S_IDLE with no event.
    - other (including E0/F0): emit release, ext=0, -> S_IDLE.
  - S_E0F0:
    - 00 or FF -> S_IDLE with no event.
    - other: emit release, ext=1, -> S_IDLE.
- Timeout:
  - The counter clears on every rx_valid and in S_IDLE.
  - It increments every cycle in S_E0, S_F0 and S_E0F0.
  - When it reaches TIMEOUT_CYC-1: state -> S_IDLE, no event.
  - If rx_valid arrives in that same cycle, the byte is processed and the timeout is ignored.
- Emit (evaluated in the rx_valid cycle of the final byte):
  - Load condition: output register empty (evt_valid=0), or evt_valid && evt_ready in the same cycle.
  - On load: evt_code/evt_ext/evt_break are updated and evt_valid=1 on the next cycle (latency 1).
  - Otherwise the event is dropped and overflow is set.
  - If the event is loaded and is a press, led <= code.
- Output hold:
  - evt_valid, evt_code, evt_ext and evt_break stay stable until the handshake.
  - evt_valid falls the cycle after a handshake unless a new event loads in that same cycle.
- Modifiers:
  - Updated on every decoded event, whether or not the event was loaded or dropped.
  - Press sets the flag, release clears it.
  - Code map: 12 -> lshift; 59 -> rshift; 14 -> ctrl (ext 0 or 1); 11 -> alt (ext 0 or 1).
  - mod_shift = lshift | rshift.
  - mod_* are registered and reflect the event from the previous cycle.
- overflow:
  - Set by a dropped event.
  - Cleared by ovf_clr.
  - Set wins if both happen in the same cycle.
- Typematic repeats (repeated presses) each produce an event; no suppression.

Decomposition:
- Package ps2_kbd_pkg:
  - FSM state encoding;
  - prefix constants PFX_EXT=8'hE0 and PFX_BRK=8'hF0;
  - ignored-byte constants (AA, FA, FE, EE, 00, FF);
  - modifier codes LSHIFT=8'h12, RSHIFT=8'h59, CTRL=8'h14, ALT=8'h11.
- One sub-module, ps2_evt_buf: a single-entry valid/ready holding register with load/drop/overflow logic.
- The prefix FSM, timeout counter and modifier flags stay in the top module.

Test Plan:
- Bytes 1C, F0, 1C with ready=1 -> event {1C, ext0, brk0} one cycle after the first byte; event {1C, ext0, brk1} after the third byte; led=1C.
- Bytes E0, 75, then E0, F0, 75 -> {75, ext1, brk0} then {75, ext1, brk1}; no event emitted on any prefix byte.
- Press 12, press 59, release 12 -> mod_shift 1, 1, 1; then release 59 -> mod_shift 0. Ctrl via E0 14 with release E0 F0 14 -> mod_ctrl 1 then 0.
- evt_ready=0, bytes 1C then 32 -> first event held unchanged; second dropped; overflow=1. Then ovf_clr -> overflow=0. A final byte arriving in the same cycle as a handshake -> new event loads with no overflow.
- Byte F0, then idle for TIMEOUT_CYC cycles, then 1C -> press {1C, brk0}, not a release.
- Byte E0 with rx_err=1, then 75 -> {75, ext0, brk0}. Reset asserted after E0 F0 -> no event; all outputs return to 0.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// PS/2 Set-2 keyboard decode shared types.
// States, prefix/ignore bytes, modifier codes.
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_E0,
    S_F0,
    S_E0F0
  } state_t;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  localparam logic [7:0] IGN_BAT  = 8'hAA;
  localparam logic [7:0] IGN_ACK  = 8'hFA;
  localparam logic [7:0] IGN_RSND = 8'hFE;
  localparam logic [7:0] IGN_ECHO = 8'hEE;
  localparam logic [7:0] IGN_ERR0 = 8'h00;
  localparam logic [7:0] IGN_ERR1 = 8'hFF;

  localparam logic [7:0] LSHIFT = 8'h12;
  localparam logic [7:0] RSHIFT = 8'h59;
  localparam logic [7:0] CTRL   = 8'h14;
  localparam logic [7:0] ALT    = 8'h11;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } evt_t;

  // Keyboard error/overrun bytes: abort any sequence.
  function automatic logic is_null(
    input logic [7:0] b
  );
    return (b == IGN_ERR0) || (b == IGN_ERR1);
  endfunction

  // Bytes that never start a key event.
  function automatic logic is_ignored(
    input logic [7:0] b
  );
    return is_null(b)
        || (b == IGN_BAT)
        || (b == IGN_ACK)
        || (b == IGN_RSND)
        || (b == IGN_ECHO);
  endfunction

endpackage

// File: rtl/ps2_evt_buf.sv
// Single-entry valid/ready event holding register.
// Loads when empty or draining; else drops and flags overflow.
module ps2_evt_buf
  import ps2_kbd_pkg::*;
(
  input  logic       dspclk,
  input  logic       reset,
  input  logic       load_req,
  input  evt_t       load_evt,
  input  logic       evt_ready,
  input  logic       ovf_clr,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       overflow,
  output logic       loaded
);

  logic drain;

  assign drain  = evt_valid && evt_ready;
  assign loaded = load_req && (!evt_valid || evt_ready);

  // Hold register: load, drain, or keep.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      evt_valid <= 1'b0;
      evt_code  <= '0;
      evt_ext   <= 1'b0;
      evt_break <= 1'b0;
    end else if (loaded) begin
      evt_valid <= 1'b1;
      evt_code  <= load_evt.code;
      evt_ext   <= load_evt.ext;
      evt_break <= load_evt.brk;
    end else if (drain) begin
      evt_valid <= 1'b0;
    end
  end

  // Sticky overflow; a drop in the clear cycle wins.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (load_req && !loaded) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code to key-event decoder.
// Folds E0/F0 prefixes, tracks modifiers, times out stale prefixes.
module ps2_scancode_decoder
  import ps2_kbd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TO_W        = 17
) (
  input  logic       dspclk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       mod_shift,
  output logic       mod_ctrl,
  output logic       mod_alt,
  output logic       overflow,
  input  logic       ovf_clr,
  output logic [7:0] led
);

  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYC - 1);

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            emit;
  evt_t            ev;
  logic            loaded;
  logic            lshift;
  logic            rshift;
  logic            ctrl;
  logic            alt;

  assign to_hit = (state != S_IDLE) && (to_cnt == TO_LAST);

  // Prefix decode: next state and event for this byte.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    ev.code   = rx_data;
    ev.ext    = 1'b0;
    ev.brk    = 1'b0;
    if (rx_valid && rx_err) begin
      state_nxt = S_IDLE;
    end else if (rx_valid) begin
      unique case (state)
        S_IDLE: begin
          if (rx_data == PFX_EXT) begin
            state_nxt = S_E0;
          end else if (rx_data == PFX_BRK) begin
            state_nxt = S_F0;
          end else if (!is_ignored(rx_data)) begin
            emit = 1'b1;
          end
        end
        S_E0: begin
          if (rx_data == PFX_BRK) begin
            state_nxt = S_E0F0;
          end else if (rx_data == PFX_EXT) begin
            state_nxt = S_E0;
          end else begin
            state_nxt = S_IDLE;
            emit      = !is_null(rx_data);
            ev.ext    = 1'b1;
          end
        end
        S_F0: begin
          state_nxt = S_IDLE;
          emit      = !is_null(rx_data);
          ev.brk    = 1'b1;
        end
        S_E0F0: begin
          state_nxt = S_IDLE;
          emit      = !is_null(rx_data);
          ev.ext    = 1'b1;
          ev.brk    = 1'b1;
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (to_hit) begin
      state_nxt = S_IDLE;
    end
  end

  // FSM state and inter-byte timeout counter.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      state  <= S_IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rx_valid || state == S_IDLE || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Modifier flags follow every decoded event, loaded or not.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      lshift <= 1'b0;
      rshift <= 1'b0;
      ctrl   <= 1'b0;
      alt    <= 1'b0;
    end else if (emit) begin
      if (ev.code == LSHIFT) lshift <= !ev.brk;
      if (ev.code == RSHIFT) rshift <= !ev.brk;
      if (ev.code == CTRL)   ctrl   <= !ev.brk;
      if (ev.code == ALT)    alt    <= !ev.brk;
    end
  end

  // LED shows the last press that made it into the output.
  always_ff @(posedge dspclk) begin
    if (reset) begin
      led <= '0;
    end else if (loaded && !ev.brk) begin
      led <= ev.code;
    end
  end

  assign mod_shift = lshift | rshift;
  assign mod_ctrl  = ctrl;
  assign mod_alt   = alt;

  ps2_evt_buf u_buf (
    .dspclk    (dspclk),
    .reset     (reset),
    .load_req  (emit),
    .load_evt  (ev),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .overflow  (overflow),
    .loaded    (loaded)
  );

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed steps then
// random byte streams against a prefix-level reference model.
module tb_ps2_scancode_decoder;

  localparam int T = 16;

  logic       dspclk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic       evt_ready = 1'b0;
  logic       ovf_clr = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       mod_shift;
  logic       mod_ctrl;
  logic       mod_alt;
  logic       overflow;
  logic [7:0] led;

  int n_assert = 0;
  int n_fail = 0;
  logic rdy = 1'b1;

  // reference model state
  bit         m_e0;
  bit         m_f0;
  int         m_idle;
  bit         m_v;
  bit [7:0]   m_code;
  bit         m_ext;
  bit         m_brk;
  bit         m_ovf;
  bit [7:0]   m_led;
  bit         held [256];

  always #5 dspclk = ~dspclk;

  ps2_scancode_decoder #(
    .TIMEOUT_CYC (T),
    .TO_W        (5)
  ) dut (
    .dspclk    (dspclk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .mod_shift (mod_shift),
    .mod_ctrl  (mod_ctrl),
    .mod_alt   (mod_alt),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .led       (led)
  );

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic model_rst();
    m_e0 = 0; m_f0 = 0; m_idle = 0;
    m_v = 0; m_code = 0; m_ext = 0; m_brk = 0;
    m_ovf = 0; m_led = 0;
    foreach (held[i]) held[i] = 0;
  endtask

  // One cycle of the keyboard protocol, byte-level view.
  task automatic model_step(
    input logic [7:0] d,
    input logic v, input logic e,
    input logic r, input logic c
  );
    bit ev = 0;
    bit [7:0] ec = d;
    bit ex = 0;
    bit eb = 0;
    bit hs = m_v && r;
    bit take;
    if (v) begin
      if ((m_e0 || m_f0) && m_idle >= T) begin
        m_e0 = 0; m_f0 = 0;
      end
      m_idle = 0;
      if (e || d == 8'h00 || d == 8'hFF) begin
        m_e0 = 0; m_f0 = 0;
      end else if (!m_e0 && !m_f0 &&
                   (d == 8'hAA || d == 8'hFA ||
                    d == 8'hFE || d == 8'hEE)) begin
        ev = 0;
      end else if (m_f0) begin
        ev = 1; ex = m_e0; eb = 1;
        m_e0 = 0; m_f0 = 0;
      end else if (d == 8'hE0) begin
        m_e0 = 1;
      end else if (d == 8'hF0) begin
        m_f0 = 1;
      end else begin
        ev = 1; ex = m_e0; eb = 0;
        m_e0 = 0;
      end
    end else begin
      m_idle++;
    end
    take = ev && (!m_v || r);
    if (ev) held[ec] = !eb;
    if (take) begin
      m_v = 1; m_code = ec; m_ext = ex; m_brk = eb;
      if (!eb) m_led = ec;
    end else if (hs) begin
      m_v = 0;
    end
    if (ev && !take) m_ovf = 1;
    else if (c) m_ovf = 0;
  endtask

  task automatic compare();
    chk("evt_valid", 8'(evt_valid), 8'(m_v));
    chk("evt_code", evt_code, m_code);
    chk("ext_brk", {6'd0, evt_ext, evt_break},
        {6'd0, m_ext, m_brk});
    chk("mods", {5'd0, mod_shift, mod_ctrl, mod_alt},
        {5'd0, held[8'h12] | held[8'h59],
         held[8'h14], held[8'h11]});
    chk("overflow", 8'(overflow), 8'(m_ovf));
    chk("led", led, m_led);
  endtask

  task automatic put(
    input logic [7:0] d, input logic v, input logic e,
    input logic clr, input logic rst
  );
    reset = rst; rx_data = d; rx_valid = v;
    rx_err = e; evt_ready = rdy; ovf_clr = clr;
    if (rst) model_rst();
    else model_step(d, v, e, rdy, clr);
    @(negedge dspclk);
    compare();
    reset = 0; rx_valid = 0; rx_err = 0; ovf_clr = 0;
  endtask

  task automatic send(input logic [7:0] d);
    put(d, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      put(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] ign [6];
    logic [7:0] mods [4];
    ign  = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    mods = '{8'h12, 8'h59, 8'h14, 8'h11};

    @(negedge dspclk);
    put(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    put(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_valid", 8'(evt_valid), 8'h00);
    chk("rst_led", led, 8'h00);

    // press/release 1C
    rdy = 1;
    send(8'h1C);
    chk("p1c_valid", 8'(evt_valid), 8'h01);
    chk("p1c_code", evt_code, 8'h1C);
    chk("p1c_brk", 8'(evt_break), 8'h00);
    send(8'hF0);
    chk("f0_noevt", 8'(evt_valid), 8'h00);
    send(8'h1C);
    chk("r1c_brk", 8'(evt_break), 8'h01);
    chk("r1c_led", led, 8'h1C);
    idle(1);

    // extended press/release 75
    send(8'hE0);
    chk("e0_noevt", 8'(evt_valid), 8'h00);
    send(8'h75);
    chk("e75_code", evt_code, 8'h75);
    chk("e75_ext", 8'(evt_ext), 8'h01);
    send(8'hE0);
    send(8'hF0);
    chk("e0f0_noevt", 8'(evt_valid), 8'h00);
    send(8'h75);
    chk("re75_eb", {6'd0, evt_ext, evt_break}, 8'h03);
    idle(1);

    // shift and ctrl tracking
    send(8'h12);
    chk("sh_a", 8'(mod_shift), 8'h01);
    send(8'h59);
    send(8'hF0); send(8'h12);
    chk("sh_b", 8'(mod_shift), 8'h01);
    send(8'hF0); send(8'h59);
    chk("sh_c", 8'(mod_shift), 8'h00);
    send(8'hE0); send(8'h14);
    chk("ct_a", 8'(mod_ctrl), 8'h01);
    send(8'hE0); send(8'hF0); send(8'h14);
    chk("ct_b", 8'(mod_ctrl), 8'h00);
    idle(1);

    // backpressure, overflow, clear, load on handshake
    rdy = 0;
    send(8'h1C);
    send(8'h32);
    chk("bp_code", evt_code, 8'h1C);
    chk("bp_ovf", 8'(overflow), 8'h01);
    put(8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_clr", 8'(overflow), 8'h00);
    rdy = 1;
    send(8'h32);
    chk("hs_code", evt_code, 8'h32);
    chk("hs_ovf", 8'(overflow), 8'h00);
    idle(1);

    // timeout boundary
    send(8'hF0); idle(T); send(8'h1C);
    chk("to_brk", 8'(evt_break), 8'h00);
    send(8'hF0); idle(T - 1); send(8'h1C);
    chk("noto_brk", 8'(evt_break), 8'h01);
    idle(1);

    // parity error aborts prefix
    put(8'hE0, 1'b1, 1'b1, 1'b0, 1'b0);
    send(8'h75);
    chk("err_ext", 8'(evt_ext), 8'h00);
    idle(1);

    // reset mid-sequence
    send(8'hE0); send(8'hF0);
    put(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("mid_rst", {evt_valid, overflow, mod_shift,
        mod_ctrl, mod_alt, evt_ext, evt_break, 1'b0},
        8'h00);
    send(8'h75);
    chk("mid_rst_brk", 8'(evt_break), 8'h00);

    // random streams
    for (int n = 0; n < 1500; n++) begin
      int sel = $urandom_range(0, 15);
      int gs  = $urandom_range(0, 9);
      logic [7:0] b = 8'($urandom_range(0, 255));
      logic er = 0;
      rdy = ($urandom_range(0, 3) != 0);
      if (sel < 3) b = 8'hE0;
      else if (sel < 5) b = 8'hF0;
      else if (sel == 5) b = ign[$urandom_range(0, 5)];
      else if (sel == 6) er = 1;
      else if (sel < 9) b = mods[$urandom_range(0, 3)];
      put(b, 1'b1, er, ($urandom_range(0, 15) == 0),
          1'b0);
      if (gs == 0) idle(T - 1 + $urandom_range(0, 2));
      else if (gs < 4) idle($urandom_range(1, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
